// File: rtl/mem_responder.sv
// Fixed-latency backing-memory responder for the cache-line request/response
// protocol. Requests are queued in order and answered no sooner than LATENCY
// cycles after acceptance. Line writes commit to the local array when their
// response is popped.
module mem_responder #(
    parameter int LINE_BITS = 512,
    parameter int ADDR_BITS = 32,
    parameter int ID_BITS   = 4,
    parameter int NUM_LINES = 256,
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [ID_BITS-1:0]   req_id,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LINE_BITS-1:0] req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_op,
    output logic [ID_BITS-1:0]   rsp_id,
    output logic [ADDR_BITS-1:0] rsp_addr,
    output logic [LINE_BITS-1:0] rsp_data,
    output logic                 busy
);

    localparam int OFF = $clog2(LINE_BITS / 8);
    localparam int IDX = $clog2(NUM_LINES);
    localparam int PW  = $clog2(DEPTH);
    localparam int QW  = PW + 1;
    localparam int CW  = $clog2(LATENCY + 1);

    // Queue payload storage, one slot per outstanding request
    logic                 q_op   [DEPTH];
    logic [ID_BITS-1:0]   q_id   [DEPTH];
    logic [ADDR_BITS-1:0] q_addr [DEPTH];
    logic [LINE_BITS-1:0] q_data [DEPTH];
    logic [CW-1:0]        q_cnt  [DEPTH];

    // Queue bookkeeping
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [QW-1:0] count;

    // Backing line array
    logic [LINE_BITS-1:0] mem [NUM_LINES];

    logic             push;
    logic             pop;
    logic [DEPTH-1:0] live;
    logic [IDX-1:0]   head_idx;

    assign req_ready = (count < QW'(DEPTH));
    assign busy      = (count != '0);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign head_idx  = q_addr[head][OFF +: IDX];

    // Response outputs are taken purely from the head slot and the array
    always_comb begin
        rsp_valid = (count != '0) && (q_cnt[head] == '0);
        rsp_op    = q_op[head];
        rsp_id    = q_id[head];
        rsp_addr  = q_addr[head];
        rsp_data  = q_op[head] ? q_data[head] : mem[head_idx];
    end

    // Mark slots that currently hold an outstanding request (distance from head < count)
    always_comb begin
        logic [PW-1:0] rel;
        live = '0;
        rel  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel     = PW'(i) - head;
            live[i] = ({1'b0, rel} < count);
        end
    end

    // Pointer and occupancy register
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + QW'(1);
                2'b01:   count <= count - QW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload slots: age every live entry toward zero, then capture a new request at tail
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live[i] && (q_cnt[i] != '0)) begin
                q_cnt[i] <= q_cnt[i] - CW'(1);
            end
        end
        if (push) begin
            q_op[tail]   <= req_op;
            q_id[tail]   <= req_id;
            q_addr[tail] <= req_addr;
            q_data[tail] <= req_data;
            q_cnt[tail]  <= CW'(LATENCY - 1);
        end
    end

    // Commit a write to the array only when its response leaves the queue;
    // a pop coinciding with reset is discarded along with the rest of the queue
    always_ff @(posedge clk) begin
        if (!reset && pop && q_op[head]) begin
            mem[head_idx] <= q_data[head];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with default geometry
// (512-bit lines, DEPTH=4, LATENCY=8).
module tb_mem_responder;

    localparam int LB = 512;
    localparam int AB = 32;
    localparam int IB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [IB-1:0] req_id;
    logic [AB-1:0] req_addr;
    logic [LB-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_op;
    logic [IB-1:0] rsp_id;
    logic [AB-1:0] rsp_addr;
    logic [LB-1:0] rsp_data;
    logic          busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    localparam logic [LB-1:0] PAT_A = {16{32'hA5A5_0001}};
    localparam logic [LB-1:0] PAT_B = {16{32'hB00B_0002}};
    localparam logic [LB-1:0] PAT_C = {16{32'hC0C0_0003}};

    mem_responder #(
        .LINE_BITS(LB),
        .ADDR_BITS(AB),
        .ID_BITS  (IB),
        .NUM_LINES(256),
        .DEPTH    (4),
        .LATENCY  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_id   (req_id),
        .req_addr (req_addr),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_op   (rsp_op),
        .rsp_id   (rsp_id),
        .rsp_addr (rsp_addr),
        .rsp_data (rsp_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic send(input logic op, input logic [IB-1:0] id, input logic [AB-1:0] addr,
                        input logic [LB-1:0] data);
        int unsigned n;
        logic        rdy;
        n         = 0;
        rdy       = 1'b0;
        req_op    = op;
        req_id    = id;
        req_addr  = addr;
        req_data  = data;
        req_valid = 1'b1;
        do begin
            rdy = req_ready;
            tick();
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check("send_timeout", '0, '1);
        req_valid = 1'b0;
    endtask

    // Wait for the next response (bounded), check it, then pop it
    task automatic recv(input string tag, input logic op, input logic [IB-1:0] id,
                        input logic [AB-1:0] addr, input logic [LB-1:0] data);
        int unsigned n;
        n         = 0;
        rsp_ready = 1'b0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, LB'(rsp_valid), LB'(1));
        check({tag, "_op"},    LB'(rsp_op),    LB'(op));
        check({tag, "_id"},    LB'(rsp_id),    LB'(id));
        check({tag, "_addr"},  LB'(rsp_addr),  LB'(addr));
        check({tag, "_data"},  rsp_data,       data);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int unsigned n;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_id    = '0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_rsp_valid", LB'(rsp_valid), LB'(0));
        check("rst_busy",      LB'(busy),      LB'(0));
        check("rst_req_ready", LB'(req_ready), LB'(1));

        // Single read after priming line 0x40
        send(1'b1, 4'd0, 32'h40, PAT_A);
        recv("prime_a", 1'b1, 4'd0, 32'h40, PAT_A);
        req_op    = 1'b0;
        req_id    = 4'd3;
        req_addr  = 32'h40;
        req_data  = '0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("rd_latency", LB'(n), LB'(8));
        check("rd_id",      LB'(rsp_id), LB'(3));
        check("rd_op",      LB'(rsp_op), LB'(0));
        check("rd_data",    rsp_data, PAT_A);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Back-to-back write then read of the same line
        req_op    = 1'b1;
        req_id    = 4'd1;
        req_addr  = 32'h80;
        req_data  = PAT_B;
        req_valid = 1'b1;
        tick();
        n = 1;
        req_op    = 1'b0;
        req_id    = 4'd2;
        req_data  = '0;
        tick();
        n++;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("wr_latency", LB'(n), LB'(8));
        check("wr_id",      LB'(rsp_id), LB'(1));
        check("wr_op",      LB'(rsp_op), LB'(1));
        check("wr_data",    rsp_data, PAT_B);
        tick();
        check("rar_valid",  LB'(rsp_valid), LB'(1));
        check("rar_id",     LB'(rsp_id), LB'(2));
        check("rar_data",   rsp_data, PAT_B);
        tick();
        rsp_ready = 1'b0;
        check("b2b_idle",   LB'(busy), LB'(0));

        // Full queue: four accepted, fifth held until the first pop
        for (int unsigned i = 0; i < 4; i++) begin
            check("full_pre_ready", LB'(req_ready), LB'(1));
            req_op    = 1'b0;
            req_id    = IB'(4 + i);
            req_addr  = 32'h40;
            req_valid = 1'b1;
            tick();
        end
        check("full_ready_low", LB'(req_ready), LB'(0));
        req_id = 4'd8;
        tick();
        tick();
        check("full_held", LB'(req_ready), LB'(0));
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("full_head_id", LB'(rsp_id), LB'(4));
        check("full_still_held", LB'(req_ready), LB'(0));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("full_reraise", LB'(req_ready), LB'(1));
        tick();
        req_valid = 1'b0;
        check("full_refilled", LB'(req_ready), LB'(0));
        for (int unsigned i = 0; i < 4; i++) begin
            recv("full_drain", 1'b0, IB'(5 + i), 32'h40, PAT_A);
        end
        check("full_idle", LB'(busy), LB'(0));

        // Backpressure: head must hold for 10 cycles, then pop exactly once
        send(1'b0, 4'd9, 32'h80, '0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        for (int unsigned i = 0; i < 10; i++) begin
            check("bp_hold_ctl", LB'({rsp_valid, rsp_op, rsp_id, rsp_addr}),
                  LB'({1'b1, 1'b0, 4'd9, 32'h80}));
            check("bp_hold_data", rsp_data, PAT_B);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_single_pop", LB'({rsp_valid, busy}), LB'(0));

        // Wrap-around stream: alternating write/read to lines 8..17, random rsp_ready
        fork
            begin
                for (int unsigned k = 0; k < 10; k++) begin
                    send(1'b1, IB'(2 * k), AB'((k + 8) << 6), {16{32'hD000_0000 + k}});
                    send(1'b0, IB'(2 * k + 1), AB'((k + 8) << 6), '0);
                end
            end
            begin
                int unsigned got;
                int unsigned cyc;
                int unsigned k;
                got = 0;
                cyc = 0;
                while (got < 20 && cyc < 2000) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    if (rsp_valid && rsp_ready) begin
                        k = got / 2;
                        check("wrap_id",   LB'(rsp_id), LB'(got % 16));
                        check("wrap_op",   LB'(rsp_op), LB'((got % 2) == 0));
                        check("wrap_addr", LB'(rsp_addr), LB'((k + 8) << 6));
                        check("wrap_data", rsp_data, {16{32'hD000_0000 + k}});
                        if (got == 19) check("wrap_busy_last", LB'(busy), LB'(1));
                        got++;
                    end
                    tick();
                    cyc++;
                end
                rsp_ready = 1'b0;
                check("wrap_count", LB'(got), LB'(20));
                check("wrap_busy_done", LB'(busy), LB'(0));
            end
        join

        // Reset mid-flight drops queued requests, including a pending write to 0xC0
        send(1'b1, 4'd1, 32'hC0, PAT_C);
        send(1'b0, 4'd2, 32'h40, '0);
        send(1'b1, 4'd3, 32'h100, PAT_B);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("mid_head_id", LB'(rsp_id), LB'(1));
        reset     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        reset     = 1'b0;
        rsp_ready = 1'b0;
        check("mid_rsp_valid", LB'(rsp_valid), LB'(0));
        check("mid_busy",      LB'(busy),      LB'(0));
        check("mid_req_ready", LB'(req_ready), LB'(1));
        send(1'b0, 4'd5, 32'hC0, '0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("mid_rd_id",   LB'(rsp_id), LB'(5));
        check("mid_dropped", LB'(rsp_data == PAT_C), LB'(0));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("mid_idle", LB'(busy), LB'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Fixed-latency backing-memory responder: the responding end of the cache-line request/response protocol the L2 drives toward memory. It accepts line read and write requests over a valid/ready handshake and queues them in order, with up to DEPTH outstanding. It returns one response per request, no earlier than LATENCY cycles after acceptance. It holds a NUM_LINES-entry line array that writes update and reads return.

## Interface
Parameters:
- LINE_BITS, 512, line data width; line bytes = LINE_BITS/8, offset bits OFF = clog2(LINE_BITS/8)
- ADDR_BITS, 32, byte address width
- ID_BITS, 4, requester transaction tag width
- NUM_LINES, 256, backing array depth (power of 2); index bits IDX = clog2(NUM_LINES)
- DEPTH, 4, max outstanding requests (power of 2, >=2)
- LATENCY, 8, minimum accept-to-response cycles (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_op  in  1  0=read line, 1=write line
- req_id  in  ID_BITS  transaction tag
- req_addr  in  ADDR_BITS  byte address
- req_data  in  LINE_BITS  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester consumes response
- rsp_op  out  1  echo of req_op
- rsp_id  out  ID_BITS  echo of req_id
- rsp_addr  out  ADDR_BITS  echo of req_addr
- rsp_data  out  LINE_BITS  read: line contents; write: echo of written data
- busy  out  1  any request outstanding

## Operation
- Queue: DEPTH-entry circular FIFO, head/tail pointers plus occupancy count (clog2(DEPTH)+1 bits).
- Each entry holds {op, id, addr, data, cnt}. cnt is clog2(LATENCY+1) bits.
- Accept: req_valid && req_ready. The request is written at tail, cnt = LATENCY-1, tail increments modulo DEPTH.
- req_ready = (count < DEPTH). There is no full-bypass: a pop in the same cycle does not raise req_ready when full.
- Every valid entry with cnt != 0 decrements by 1 per cycle and saturates at 0.
- rsp_valid = count != 0 && head.cnt == 0. rsp_op, rsp_id and rsp_addr come from head.
- rsp_data = head.op ? head.data : mem[head.addr[OFF +: IDX]].
- Response handshake: rsp_valid && rsp_ready pops head and increments head modulo DEPTH.
- On popping a write, mem[index] <= head.data.
- Writes commit at response pop, so strictly in-order service makes a later read of the same line return the written data.
- Line index = addr[OFF +: IDX]. Upper address bits alias, and addr[OFF-1:0] is ignored.
- Simultaneous accept and pop: count unchanged; both pointers advance.
- busy = count != 0.
- Reset: head = tail = count = 0, so rsp_valid = 0, busy = 0 and req_ready = 1 on the cycle after reset. Entry payloads and mem are not reset, and mem contents are undefined until written. Reset mid-operation drops all queued requests without committing pending writes.

## Timing
- Request accepted at edge of cycle T: earliest rsp_valid is cycle T+LATENCY. With LATENCY=1, that is the next cycle.
- Back-to-back accepts at T and T+1 give responses at T+LATENCY and T+LATENCY+1 when rsp_ready is held high, for a sustained throughput of 1 per cycle.
- While rsp_valid && !rsp_ready, every rsp_* output holds stable, including rsp_data. No write to the same index can commit in between, because only the head commits.
- Responses are strictly in acceptance order and are never dropped or duplicated.
- Outputs are combinational from FIFO and array state. There is no combinational path from req_* to rsp_*, and none from rsp_ready to req_ready.

## Test plan
- Single read, LATENCY=8: write line 0x40 = pattern A and drain it. Then read addr 0x40 with id 3, accepted at T. Required: rsp_valid first at T+8 with rsp_id=3, rsp_op=0, rsp_data=A.
- Write then read, back-to-back: write 0x80 = B (id 1) at T, read 0x80 (id 2) at T+1, rsp_ready=1. Required: id 1 at T+8 echoing B, id 2 at T+9 with data B.
- Full: DEPTH=4, rsp_ready=0, issue 5 requests. Required: req_ready=0 after the 4th accept and the 5th is held. The first pop re-raises req_ready the next cycle, and the 5th is accepted then.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid. Required: all rsp_* stable across those cycles, with a single pop when rsp_ready=1.
- Wrap-around: stream 20 alternating write/read requests to distinct lines with random rsp_ready. Required: ids return in order, each read returns the prior write, and busy falls only after the last pop.
- Reset mid-flight: 3 requests queued including a write to 0xC0, then assert reset. Required: next cycle rsp_valid=0, busy=0, req_ready=1. A subsequent read of 0xC0 does not return the dropped write data.
